led_seq_ctrl: RTL and testbench

LED_SEQ_CTRL -- requirements
Module: led_seq_ctrl

---
 rtl/led_seq_ctrl.sv | 137 +++++++++++++
 tb/tb_led_seq_ctrl.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/led_seq_ctrl.sv
// LED sequencer: four display modes stepped at a selectable rate, with pause,
// mode-key advance and self-recovery of corrupted single-lit patterns.
module led_seq_ctrl #(
  parameter int unsigned TICK_BASE = 50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       mode_key,
  input  logic [1:0] speed_sel,
  input  logic       pause,
  output logic [3:0] led,
  output logic [1:0] mode,
  output logic       tick
);

  typedef enum logic [1:0] {
    RUN_R  = 2'b00,
    RUN_L  = 2'b01,
    BLINK  = 2'b10,
    BOUNCE = 2'b11
  } mode_e;

  localparam logic [26:0] BASE = 27'(TICK_BASE);

  mode_e       mode_q, mode_d;
  logic [3:0]  led_q, led_d;
  logic [25:0] cnt_q, cnt_d;
  logic        dir_right_q, dir_right_d;
  logic        tick_q, tick_d;
  logic [1:0]  spd_q, spd_d;

  logic [26:0] period;
  logic [25:0] cnt_last;
  logic [3:0]  step_led;
  logic        step_dir_right;

  function automatic logic [3:0] init_pat(input mode_e m);
    case (m)
      RUN_L:   return 4'b1110;
      BLINK:   return 4'b0000;
      default: return 4'b0111;
    endcase
  endfunction

  function automatic logic one_cold(input logic [3:0] v);
    case (v)
      4'b0111, 4'b1011, 4'b1101, 4'b1110: return 1'b1;
      default:                            return 1'b0;
    endcase
  endfunction

  always_comb begin
    period   = BASE >> spd_q;
    cnt_last = 26'(period - 27'd1);
  end

  // Pattern produced by one step of the current mode, including recovery.
  always_comb begin
    step_led       = led_q;
    step_dir_right = dir_right_q;
    case (mode_q)
      RUN_R: step_led = one_cold(led_q) ? {led_q[0], led_q[3:1]} : 4'b0111;
      RUN_L: step_led = one_cold(led_q) ? {led_q[2:0], led_q[3]} : 4'b1110;
      BLINK: step_led = ~led_q;
      BOUNCE: begin
        if (!one_cold(led_q)) begin
          step_led       = 4'b0111;
          step_dir_right = 1'b1;
        end else begin
          step_led = dir_right_q ? {led_q[0], led_q[3:1]} : {led_q[2:0], led_q[3]};
          if (step_led == 4'b1110)
            step_dir_right = 1'b0;
          else if (step_led == 4'b0111)
            step_dir_right = 1'b1;
        end
      end
      default: step_led = 4'b0111;
    endcase
  end

  // Priority: mode key, then pause, then speed change, then counting.
  always_comb begin
    mode_d      = mode_q;
    led_d       = led_q;
    cnt_d       = cnt_q;
    dir_right_d = dir_right_q;
    tick_d      = 1'b0;
    spd_d       = pause ? spd_q : speed_sel;

    if (mode_key) begin
      case (mode_q)
        RUN_R:   mode_d = RUN_L;
        RUN_L:   mode_d = BLINK;
        BLINK:   mode_d = BOUNCE;
        BOUNCE:  mode_d = RUN_R;
        default: mode_d = RUN_R;
      endcase
      led_d       = init_pat(mode_d);
      dir_right_d = 1'b1;
      cnt_d       = '0;
    end else if (pause) begin
      cnt_d = cnt_q;
    end else if (speed_sel != spd_q) begin
      cnt_d = '0;
    end else if (cnt_q == cnt_last) begin
      cnt_d       = '0;
      tick_d      = 1'b1;
      led_d       = step_led;
      dir_right_d = step_dir_right;
    end else begin
      cnt_d = cnt_q + 26'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q      <= RUN_R;
      led_q       <= 4'b0111;
      cnt_q       <= '0;
      dir_right_q <= 1'b1;
      tick_q      <= 1'b0;
      spd_q       <= 2'b00;
    end else begin
      mode_q      <= mode_d;
      led_q       <= led_d;
      cnt_q       <= cnt_d;
      dir_right_q <= dir_right_d;
      tick_q      <= tick_d;
      spd_q       <= spd_d;
    end
  end

  assign led  = led_q;
  assign mode = mode_q;
  assign tick = tick_q;

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Scoreboard bench for led_seq_ctrl: driver pushes model predictions, monitor
// pops and compares one entry per clock.
module tb_led_seq_ctrl;

  localparam int TB = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       mode_key = 1'b0;
  logic [1:0] speed_sel = 2'b00;
  logic       pause = 1'b0;
  logic [3:0] led;
  logic [1:0] mode;
  logic       tick;

  int checks = 0;
  int errors = 0;

  logic [6:0] exp_q[$];

  // Reference model: pattern position within each mode's listed sequence.
  int m_mode, m_idx, m_cnt, m_spdq;
  logic [3:0] seq_run_r[4] = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};
  logic [3:0] seq_run_l[4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
  logic [3:0] seq_blink[2] = '{4'b0000, 4'b1111};
  logic [3:0] seq_bounce[6] = '{4'b0111, 4'b1011, 4'b1101, 4'b1110, 4'b1101, 4'b1011};

  led_seq_ctrl #(.TICK_BASE(TB)) dut (
    .clk       (clk),
    .rst       (rst),
    .mode_key  (mode_key),
    .speed_sel (speed_sel),
    .pause     (pause),
    .led       (led),
    .mode      (mode),
    .tick      (tick)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] model_led(int md, int idx);
    case (md)
      0:       return seq_run_r[idx % 4];
      1:       return seq_run_l[idx % 4];
      2:       return seq_blink[idx % 2];
      default: return seq_bounce[idx % 6];
    endcase
  endfunction

  function automatic int period_of(int s);
    return TB / (1 << s);
  endfunction

  task automatic model_reset();
    m_mode = 0; m_idx = 0; m_cnt = 0; m_spdq = 0;
  endtask

  // Called at a negedge: drive inputs, predict the next edge, wait one cycle.
  task automatic cycle(input logic k, input logic p, input logic [1:0] s);
    logic t;
    mode_key = k; pause = p; speed_sel = s;
    t = 1'b0;
    if (k) begin
      m_mode = (m_mode + 1) % 4; m_idx = 0; m_cnt = 0;
    end else if (p) begin
    end else if (int'(s) != m_spdq) begin
      m_cnt = 0;
    end else if (m_cnt == period_of(m_spdq) - 1) begin
      m_cnt = 0; t = 1'b1; m_idx++;
    end else begin
      m_cnt++;
    end
    if (!p) m_spdq = int'(s);
    exp_q.push_back({t, model_led(m_mode, m_idx), 2'(m_mode)});
    @(negedge clk);
  endtask

  task automatic check_reset_outputs();
    checks++;
    if (led !== 4'b0111) begin errors++; $display("FAIL rst_led got %b want 0111", led); end
    checks++;
    if (mode !== 2'b00) begin errors++; $display("FAIL rst_mode got %b want 00", mode); end
    checks++;
    if (tick !== 1'b0) begin errors++; $display("FAIL rst_tick got %b want 0", tick); end
  endtask

  // Asynchronous reset between edges; outputs checked before any clock edge.
  task automatic do_reset();
    #2 rst = 1'b1;
    #1 check_reset_outputs();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin : monitor
    logic [6:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (tick !== e[6]) begin errors++; $display("FAIL tick got %b want %b at %0t", tick, e[6], $time); end
        checks++;
        if (led !== e[5:2]) begin errors++; $display("FAIL led got %b want %b at %0t", led, e[5:2], $time); end
        checks++;
        if (mode !== e[1:0]) begin errors++; $display("FAIL mode got %b want %b at %0t", mode, e[1:0], $time); end
      end
    end
  end

  initial begin : driver
    logic k, p;
    logic [1:0] s;
    int pause_left;
    model_reset();
    @(negedge clk);
    check_reset_outputs();
    @(negedge clk);
    rst = 1'b0;

    repeat (40) cycle(1'b0, 1'b0, 2'b00);
    repeat (10) cycle(1'b0, 1'b0, 2'b11);
    repeat (2)  cycle(1'b0, 1'b0, 2'b01);
    repeat (12) cycle(1'b0, 1'b0, 2'b01);
    for (int unsigned i = 0; i < 4; i++) begin
      cycle(1'b1, 1'b0, 2'b01);
      repeat (3) cycle(1'b0, 1'b0, 2'b01);
    end
    // Key exactly on the last count of a period.
    while (m_cnt != period_of(m_spdq) - 1) cycle(1'b0, 1'b0, 2'b01);
    cycle(1'b1, 1'b0, 2'b01);
    cycle(1'b1, 1'b0, 2'b01);
    cycle(1'b1, 1'b0, 2'b01);
    repeat (10) cycle(1'b0, 1'b0, 2'b11);
    repeat (5)  cycle(1'b0, 1'b0, 2'b00);
    repeat (20) cycle(1'b0, 1'b1, 2'b00);
    repeat (12) cycle(1'b0, 1'b0, 2'b00);
    repeat (3)  cycle(1'b0, 1'b1, 2'b00);
    cycle(1'b1, 1'b1, 2'b00);
    repeat (10) cycle(1'b0, 1'b1, 2'b00);
    repeat (12) cycle(1'b0, 1'b0, 2'b00);
    while (m_mode != 2) cycle(1'b1, 1'b0, 2'b11);
    repeat (5) cycle(1'b0, 1'b0, 2'b11);
    do_reset();
    repeat (12) cycle(1'b0, 1'b0, 2'b00);

    s = 2'b00;
    pause_left = 0;
    for (int unsigned n = 0; n < 2500; n++) begin
      k = ($urandom_range(0, 29) == 0) ||
          (m_cnt == period_of(m_spdq) - 1 && $urandom_range(0, 5) == 0);
      if (pause_left > 0) begin
        p = 1'b1; pause_left--;
      end else begin
        p = 1'b0;
        if ($urandom_range(0, 99) == 0) pause_left = int'($urandom_range(1, 25));
      end
      if ($urandom_range(0, 59) == 0) s = 2'($urandom_range(0, 3));
      cycle(k, p, s);
      if (n == 1200) do_reset();
    end

    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d entries left want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
